operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 SHALL have parameter RESET_OPERATION, default 4'b0000, which is the value driven on operation during and after reset.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: the reset is asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: instruction is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the stage accepts the instruction this cycle.
REQ-006 SHALL have port instruction, input, 32 bits: RV32I instruction word.
REQ-007 SHALL have port out_valid, output, 1 bit: the ALU fields are valid.
REQ-008 SHALL have port out_ready, input, 1 bit: the ALU/writeback consumer takes the fields.
REQ-009 SHALL have port operation, output, 4 bits: the ALU operation code.
REQ-010 SHALL have ports operand1 and operand2, output, 32 bits each: the ALU operands.
REQ-011 SHALL have port out_rd, output, 5 bits: the destination register of the issued instruction.
REQ-012 SHALL have port illegal, output, 1 bit: one-cycle pulse when an unsupported instruction is accepted.
REQ-013 SHALL have writeback ports wb_valid (input, 1 bit), wb_rd (input, 5 bits) and wb_data (input, 32 bits): the result write into the register file.

Function
REQ-014 SHALL decode opcode 0110011 (OP) with operation = {instruction[30], funct3}.
- funct7 0000000 is legal for any funct3 except 010 and 011.
- funct7 0100000 is legal only for funct3 000 and 101.
REQ-015 SHALL decode opcode 0010011 (OP-IMM) with operation = {0, funct3} and operand2 = sign-extended instruction[31:20].
- funct3 001 is legal only with imm[11:5] = 0.
- funct3 101 is legal only with imm[11:5] of 0000000 (operation 0101) or 0100000 (operation 1101).
REQ-016 SHALL treat any other opcode, and funct3 010 or 011, as illegal.
REQ-017 SHALL read rs1 and rs2 from a 32x32 register file; x0 always reads 0.
REQ-018 SHALL write wb_data to register wb_rd on a clock edge with wb_valid = 1; writes with wb_rd = 0 are ignored.
REQ-019 SHALL bypass wb_data to an operand whose source register equals a nonzero wb_rd while wb_valid = 1 in the same cycle.
REQ-020 SHALL keep a 32-bit busy scoreboard.
- Set bit rd when a legal instruction with rd != 0 is accepted.
- Clear bit wb_rd when wb_valid = 1.
- When the same register is set and cleared in one cycle, set wins.
REQ-021 SHALL detect a hazard when a used rs1 or rs2 is busy and is not being bypassed in that cycle; rs2 is unused for OP-IMM.
REQ-022 SHALL drive in_ready = (!out_valid || out_ready) && !hazard; in_ready may depend combinationally on instruction.
REQ-023 SHALL load operation, operands and out_rd and set out_valid on the edge after a legal acceptance (latency 1 cycle).
REQ-024 SHALL hold all outputs stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL clear out_valid after out_ready = 1 unless a new instruction is accepted in the same cycle; simultaneous drain and accept SHALL give back-to-back issue.
REQ-026 SHALL handle an accepted illegal instruction as follows:
- illegal = 1 on the next cycle;
- no out_valid;
- no busy bit set;
- the output register is unchanged.

Reset
REQ-027 SHALL reset out_valid, illegal, operand1, operand2 and out_rd to 0, operation to RESET_OPERATION, and clear all busy bits.
REQ-028 SHALL not reset register file contents x1-x31, which are undefined until written.
REQ-029 SHALL discard a pending output instruction on reset asserted mid-operation; in_ready SHALL be 0 while reset = 1.

Structure
REQ-030 SHALL take the opcode constants (OP, OP-IMM) and the 4-bit ALU operation encodings from a shared package used by the ALU and by this stage.
REQ-031 SHALL instantiate one sub-module, register_file: two combinational read ports, one synchronous write port, x0 hardwired to zero.

Verification
REQ-032 SHALL cover: writeback x1 = 5 and x2 = 3, then issue sub x3,x1,x2 -> one cycle later out_valid = 1, operation = 1000, operand1 = 5, operand2 = 3, out_rd = 3.
REQ-033 SHALL cover: srai x4,x1,2 with x1 = 0x80000000 -> operation = 1101, operand2 = 2; addi x5,x0,-1 -> operand1 = 0, operand2 = 0xFFFFFFFF.
REQ-034 SHALL cover: add x6,x1,x1 issued, then add x7,x6,x6 -> in_ready = 0 until wb_valid with wb_rd = 6, wb_data = 9; in that same cycle in_ready = 1 and the issued operands are 9 and 9.
REQ-035 SHALL cover: out_ready held 0 for 3 cycles with a second instruction waiting -> outputs stable and in_ready = 0; out_ready = 1 -> the second instruction issues on the next cycle with no bubble.
REQ-036 SHALL cover: instruction 0x00002033 (slt) or a load opcode -> illegal pulses for exactly one cycle, out_valid stays 0, no busy bit is set.
REQ-037 SHALL cover: reset asserted while out_valid = 1 -> out_valid = 0 and operation = RESET_OPERATION immediately (asynchronous); scoreboard clear afterwards, so add x8,x6,x6 issues without stall.

Source files
------------

// File: rtl/operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// operand_stage_pkg
// Shared definitions for the RV32I integer ALU path: base opcodes, funct7
// variants, the 4-bit ALU operation encoding (also used by the ALU), and the
// operand-stage decoder.
// decode_instr() returns legality, ALU operation, which source registers are
// read, and the immediate that replaces rs2 for OP-IMM.
// -----------------------------------------------------------------------------
package operand_stage_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Encoding is {funct7[5], funct3} so the ALU can decode it directly.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef struct packed {
        logic        legal;
        logic [3:0]  op;
        logic        use_rs1;
        logic        use_rs2;
        logic        imm_sel;   // operand2 comes from imm instead of rs2
        logic [31:0] imm;
    } decode_t;

    function automatic decode_t decode_instr(input logic [31:0] instr);
        decode_t    d;
        logic [2:0] f3;
        logic [6:0] f7;
        f3        = instr[14:12];
        f7        = instr[31:25];
        d.legal   = 1'b0;
        d.op      = ALU_ADD;
        d.use_rs1 = 1'b0;
        d.use_rs2 = 1'b0;
        d.imm_sel = 1'b0;
        d.imm     = {{20{instr[31]}}, instr[31:20]};
        case (instr[6:0])
            OPCODE_OP: begin
                d.op      = {instr[30], f3};
                d.use_rs1 = 1'b1;
                d.use_rs2 = 1'b1;
                if (f7 == FUNCT7_BASE) begin
                    d.legal = (f3 != 3'b010) && (f3 != 3'b011);
                end else if (f7 == FUNCT7_ALT) begin
                    d.legal = (f3 == 3'b000) || (f3 == 3'b101);
                end
            end
            OPCODE_OP_IMM: begin
                d.op      = {1'b0, f3};
                d.use_rs1 = 1'b1;
                d.imm_sel = 1'b1;
                case (f3)
                    3'b010, 3'b011: d.legal = 1'b0;
                    3'b001: begin
                        d.legal = (f7 == FUNCT7_BASE);
                        d.imm   = {27'd0, instr[24:20]};
                    end
                    3'b101: begin
                        // imm[10] selects arithmetic shift; only shamt reaches the ALU
                        d.legal = (f7 == FUNCT7_BASE) || (f7 == FUNCT7_ALT);
                        d.op    = {instr[30], f3};
                        d.imm   = {27'd0, instr[24:20]};
                    end
                    default: d.legal = 1'b1;
                endcase
            end
            default: d.legal = 1'b0;
        endcase
        // An illegal instruction reads nothing, so it can never stall on a hazard.
        if (!d.legal) begin
            d.use_rs1 = 1'b0;
            d.use_rs2 = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
// 32 x 32-bit integer register file. x0 reads as zero and ignores writes.
// Ports: clock; rs1_addr/rs2_addr -> rs1_data/rs2_data (combinational reads);
//        wr_en, wr_addr, wr_data (synchronous write on rising clock).
// Contents are not reset.
// -----------------------------------------------------------------------------
module register_file (
    input  logic        clock,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    logic [31:0] mem_q [32];

    always_ff @(posedge clock) begin
        if (wr_en && (wr_addr != 5'd0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : mem_q[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : mem_q[rs2_addr];

endmodule

// File: rtl/operand_stage.sv
// -----------------------------------------------------------------------------
// operand_stage
// Decodes RV32I OP / OP-IMM instructions, reads operands (with writeback
// bypass), tracks in-flight destinations in a busy scoreboard and presents
// ALU fields through a valid/ready output register.
// Ports: clock, reset (async, active-high);
//        in_valid/in_ready/instruction   - instruction input handshake;
//        out_valid/out_ready/operation/operand1/operand2/out_rd - ALU fields;
//        illegal  - one-cycle pulse after an unsupported instruction is taken;
//        wb_valid/wb_rd/wb_data - register file write / bypass / busy clear.
// -----------------------------------------------------------------------------
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter logic [3:0] RESET_OPERATION = 4'b0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  operation,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [4:0]  out_rd,
    output logic        illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data
);

    decode_t     dec;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        wb_live;
    logic        bypass_rs1;
    logic        bypass_rs2;
    logic        hazard;
    logic        accept;
    logic        issue;

    logic        out_valid_q, out_valid_d;
    logic        illegal_q,   illegal_d;
    logic [3:0]  operation_q, operation_d;
    logic [31:0] operand1_q,  operand1_d;
    logic [31:0] operand2_q,  operand2_d;
    logic [4:0]  out_rd_q,    out_rd_d;
    logic [31:0] busy_q,      busy_d;

    assign dec      = decode_instr(instruction);
    assign rs1_addr = instruction[19:15];
    assign rs2_addr = instruction[24:20];
    assign rd_addr  = instruction[11:7];

    register_file u_register_file (
        .clock    (clock),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rf_rs1_data),
        .rs2_data (rf_rs2_data),
        .wr_en    (wb_valid),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    // A writeback landing this cycle is forwarded, so its register is neither
    // stale in the array nor a hazard.
    assign wb_live    = wb_valid && (wb_rd != 5'd0);
    assign bypass_rs1 = wb_live && (wb_rd == rs1_addr);
    assign bypass_rs2 = wb_live && (wb_rd == rs2_addr);
    assign rs1_value  = bypass_rs1 ? wb_data : rf_rs1_data;
    assign rs2_value  = bypass_rs2 ? wb_data : rf_rs2_data;

    assign hazard = (dec.use_rs1 && busy_q[rs1_addr] && !bypass_rs1)
                 || (dec.use_rs2 && busy_q[rs2_addr] && !bypass_rs2);

    assign in_ready = !reset && (!out_valid_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && dec.legal;

    always_comb begin
        out_valid_d = out_valid_q;
        operation_d = operation_q;
        operand1_d  = operand1_q;
        operand2_d  = operand2_q;
        out_rd_d    = out_rd_q;
        illegal_d   = accept && !dec.legal;
        busy_d      = busy_q;

        if (issue) begin
            out_valid_d = 1'b1;
            operation_d = dec.op;
            operand1_d  = rs1_value;
            operand2_d  = dec.imm_sel ? dec.imm : rs2_value;
            out_rd_d    = rd_addr;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Set is applied after clear so a same-register collision stays busy.
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue && (rd_addr != 5'd0)) begin
            busy_d[rd_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            operation_q <= RESET_OPERATION;
            operand1_q  <= 32'd0;
            operand2_q  <= 32'd0;
            out_rd_q    <= 5'd0;
            busy_q      <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            operation_q <= operation_d;
            operand1_q  <= operand1_d;
            operand2_q  <= operand2_d;
            out_rd_q    <= out_rd_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign operation = operation_q;
    assign operand1  = operand1_q;
    assign operand2  = operand2_q;
    assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_operand_stage
// Directed scenarios for the operand stage followed by randomized
// instructions checked against a mnemonic-level reference model (shadow
// register file, per-mnemonic expected ALU code and operands).
// -----------------------------------------------------------------------------
module tb_operand_stage;

    localparam logic [3:0] RST_OP = 4'b1010;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  operation;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic [4:0]  out_rd;
    logic        illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_rf [32];

    operand_stage #(.RESET_OPERATION(RST_OP)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .operation   (operation),
        .operand1    (operand1),
        .operand2    (operand2),
        .out_rd      (out_rd),
        .illegal     (illegal),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Architectural value of a source register as seen in the issue cycle.
    function automatic logic [31:0] src_val(input logic [4:0] r, input logic byp,
                                            input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (byp && (wr == r)) return wd;
        return model_rf[r];
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_wb(input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = data;
        step();
        wb_valid = 1'b0;
        if (rd != 5'd0) model_rf[rd] = data;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0;
        instruction = 32'd0; wb_rd = 5'd0; wb_data = 32'd0;
        step(); step();
        n_cmp++; if ({out_valid, illegal, operation, operand1, operand2, out_rd} !== {1'b0, 1'b0, RST_OP, 32'd0, 32'd0, 5'd0}) begin
            n_err++; $display("FAIL reset_state: got %h want %h", {out_valid, illegal, operation, operand1, operand2, out_rd}, {1'b0, 1'b0, RST_OP, 32'd0, 32'd0, 5'd0});
        end
        n_cmp++; if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        reset = 1'b0;
        step();
        $display("test_reset done");
    endtask

    task automatic test_sub();
        do_wb(5'd1, 32'd5);
        do_wb(5'd2, 32'd3);
        instruction = rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd3); in_valid = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sub_ready: got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
        n_cmp++; if ({out_valid, operation, operand1, operand2, out_rd} !== {1'b1, 4'b1000, 32'd5, 32'd3, 5'd3}) begin
            n_err++; $display("FAIL sub_issue: got %h want %h", {out_valid, operation, operand1, operand2, out_rd}, {1'b1, 4'b1000, 32'd5, 32'd3, 5'd3});
        end
        do_wb(5'd3, 32'd8);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sub_drain: got %b want 0", out_valid); end
        $display("test_sub done");
    endtask

    task automatic test_imm();
        do_wb(5'd1, 32'h8000_0000);
        instruction = itype({7'h20, 5'd2}, 5'd1, 3'b101, 5'd4); in_valid = 1'b1; #1;
        step();
        n_cmp++; if ({out_valid, operation, operand1, operand2, out_rd} !== {1'b1, 4'b1101, 32'h8000_0000, 32'd2, 5'd4}) begin
            n_err++; $display("FAIL srai_issue: got %h want %h", {out_valid, operation, operand1, operand2, out_rd}, {1'b1, 4'b1101, 32'h8000_0000, 32'd2, 5'd4});
        end
        instruction = itype(12'hFFF, 5'd0, 3'b000, 5'd5); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL addi_ready: got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
        n_cmp++; if ({out_valid, operation, operand1, operand2, out_rd} !== {1'b1, 4'b0000, 32'd0, 32'hFFFF_FFFF, 5'd5}) begin
            n_err++; $display("FAIL addi_issue: got %h want %h", {out_valid, operation, operand1, operand2, out_rd}, {1'b1, 4'b0000, 32'd0, 32'hFFFF_FFFF, 5'd5});
        end
        do_wb(5'd4, 32'h11);
        do_wb(5'd5, 32'h22);
        $display("test_imm done");
    endtask

    task automatic test_hazard();
        instruction = rtype(7'h00, 5'd1, 5'd1, 3'b000, 5'd6); in_valid = 1'b1; #1;
        step();
        n_cmp++; if ({out_valid, out_rd} !== {1'b1, 5'd6}) begin
            n_err++; $display("FAIL haz_first: got %h want %h", {out_valid, out_rd}, {1'b1, 5'd6});
        end
        instruction = rtype(7'h00, 5'd6, 5'd6, 3'b000, 5'd7);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL haz_stall%0d: got %b want 0", i, in_ready); end
            step();
        end
        wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'd9; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL haz_release: got %b want 1", in_ready); end
        step(); wb_valid = 1'b0; in_valid = 1'b0; model_rf[6] = 32'd9;
        n_cmp++; if ({out_valid, operation, operand1, operand2, out_rd} !== {1'b1, 4'b0000, 32'd9, 32'd9, 5'd7}) begin
            n_err++; $display("FAIL haz_bypass: got %h want %h", {out_valid, operation, operand1, operand2, out_rd}, {1'b1, 4'b0000, 32'd9, 32'd9, 5'd7});
        end
        do_wb(5'd7, 32'h33);
        // Issue x13 while x13 is written back: the new reservation must survive.
        instruction = rtype(7'h00, 5'd1, 5'd1, 3'b000, 5'd13); in_valid = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd13; wb_data = 32'h44; #1;
        step(); wb_valid = 1'b0; model_rf[13] = 32'h44;
        instruction = rtype(7'h00, 5'd13, 5'd13, 3'b000, 5'd14); #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL set_wins: got %b want 0", in_ready); end
        in_valid = 1'b0;
        do_wb(5'd13, 32'h55);
        $display("test_hazard done");
    endtask

    task automatic test_back_to_back();
        logic [73:0] held;
        out_ready = 1'b0;
        instruction = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd9); in_valid = 1'b1; #1;
        step();
        held = {1'b1, 4'b0000, model_rf[1], model_rf[2], 5'd9};
        n_cmp++; if ({out_valid, operation, operand1, operand2, out_rd} !== held) begin
            n_err++; $display("FAIL b2b_first: got %h want %h", {out_valid, operation, operand1, operand2, out_rd}, held);
        end
        instruction = rtype(7'h00, 5'd2, 5'd2, 3'b110, 5'd10);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready%0d: got %b want 0", i, in_ready); end
            step();
            n_cmp++; if ({out_valid, operation, operand1, operand2, out_rd} !== held) begin
                n_err++; $display("FAIL b2b_hold%0d: got %h want %h", i, {out_valid, operation, operand1, operand2, out_rd}, held);
            end
        end
        out_ready = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
        n_cmp++; if ({out_valid, operation, operand1, operand2, out_rd} !== {1'b1, 4'b0110, model_rf[2], model_rf[2], 5'd10}) begin
            n_err++; $display("FAIL b2b_second: got %h want %h", {out_valid, operation, operand1, operand2, out_rd}, {1'b1, 4'b0110, model_rf[2], model_rf[2], 5'd10});
        end
        do_wb(5'd9, 32'h66);
        do_wb(5'd10, 32'h77);
        $display("test_back_to_back done");
    endtask

    task automatic test_illegal();
        do_wb(5'd11, 32'h1234);
        instruction = 32'h0000_2033; in_valid = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL slt_ready: got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
        n_cmp++; if ({illegal, out_valid, operation, out_rd} !== {1'b1, 1'b0, 4'b0110, 5'd10}) begin
            n_err++; $display("FAIL slt_pulse: got %h want %h", {illegal, out_valid, operation, out_rd}, {1'b1, 1'b0, 4'b0110, 5'd10});
        end
        step();
        n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL slt_pulse_end: got %b want 0", illegal); end
        instruction = {12'd0, 5'd1, 3'b010, 5'd11, 7'b0000011}; in_valid = 1'b1; #1;
        step(); in_valid = 1'b0;
        n_cmp++; if ({illegal, out_valid, operation, out_rd} !== {1'b1, 1'b0, 4'b0110, 5'd10}) begin
            n_err++; $display("FAIL load_pulse: got %h want %h", {illegal, out_valid, operation, out_rd}, {1'b1, 1'b0, 4'b0110, 5'd10});
        end
        step();
        n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL load_pulse_end: got %b want 0", illegal); end
        instruction = rtype(7'h00, 5'd11, 5'd11, 3'b000, 5'd12); in_valid = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL load_no_busy: got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
        n_cmp++; if ({out_valid, operand1, operand2, out_rd} !== {1'b1, 32'h1234, 32'h1234, 5'd12}) begin
            n_err++; $display("FAIL after_illegal: got %h want %h", {out_valid, operand1, operand2, out_rd}, {1'b1, 32'h1234, 32'h1234, 5'd12});
        end
        do_wb(5'd12, 32'h88);
        $display("test_illegal done");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        instruction = rtype(7'h00, 5'd1, 5'd1, 3'b000, 5'd6); in_valid = 1'b1; #1;
        step(); in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_rd} !== {1'b1, 5'd6}) begin
            n_err++; $display("FAIL rst_pending: got %h want %h", {out_valid, out_rd}, {1'b1, 5'd6});
        end
        #2; reset = 1'b1; #1;
        n_cmp++; if ({out_valid, operation} !== {1'b0, RST_OP}) begin
            n_err++; $display("FAIL rst_async: got %h want %h", {out_valid, operation}, {1'b0, RST_OP});
        end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        step();
        reset = 1'b0; out_ready = 1'b1;
        instruction = rtype(7'h00, 5'd6, 5'd6, 3'b000, 5'd8); in_valid = 1'b1; #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_no_stall: got %b want 1", in_ready); end
        step(); in_valid = 1'b0;
        n_cmp++; if ({out_valid, operation, operand1, operand2, out_rd} !== {1'b1, 4'b0000, model_rf[6], model_rf[6], 5'd8}) begin
            n_err++; $display("FAIL rst_issue: got %h want %h", {out_valid, operation, operand1, operand2, out_rd}, {1'b1, 4'b0000, model_rf[6], model_rf[6], 5'd8});
        end
        do_wb(5'd8, 32'h99);
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [4:0]  rd, rs1, rs2, sh, wr, last_rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [31:0] instr, e1, e2, wd;
        logic [3:0]  eop;
        logic        legal, is_r, is_shift, byp;
        int          cat, k;
        last_rd = 5'd8;
        for (int r = 1; r < 32; r++) do_wb(5'(r), $urandom);
        for (int n = 0; n < 60; n++) begin
            rd  = 5'($urandom_range(0, 31));
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 31));
            sh  = 5'($urandom_range(0, 31));
            imm = 12'($urandom_range(0, 4095));
            cat = $urandom_range(0, 2);
            legal = 1'b1; is_r = 1'b1; is_shift = 1'b0; eop = 4'b0000;
            f7 = 7'h00; f3 = 3'b000; instr = 32'd0;
            case (cat)
                0: begin
                    k = $urandom_range(0, 7);
                    case (k)
                        0: begin f3 = 3'b000; eop = 4'b0000; end           // add
                        1: begin f3 = 3'b001; eop = 4'b0001; end           // sll
                        2: begin f3 = 3'b100; eop = 4'b0100; end           // xor
                        3: begin f3 = 3'b101; eop = 4'b0101; end           // srl
                        4: begin f3 = 3'b110; eop = 4'b0110; end           // or
                        5: begin f3 = 3'b111; eop = 4'b0111; end           // and
                        6: begin f7 = 7'h20; f3 = 3'b000; eop = 4'b1000; end // sub
                        default: begin f7 = 7'h20; f3 = 3'b101; eop = 4'b1101; end // sra
                    endcase
                    instr = rtype(f7, rs2, rs1, f3, rd);
                end
                1: begin
                    is_r = 1'b0;
                    k = $urandom_range(0, 6);
                    case (k)
                        0: begin f3 = 3'b000; eop = 4'b0000; end                                         // addi
                        1: begin f3 = 3'b001; eop = 4'b0001; imm = {7'h00, sh}; is_shift = 1'b1; end     // slli
                        2: begin f3 = 3'b100; eop = 4'b0100; end                                         // xori
                        3: begin f3 = 3'b101; eop = 4'b0101; imm = {7'h00, sh}; is_shift = 1'b1; end     // srli
                        4: begin f3 = 3'b101; eop = 4'b1101; imm = {7'h20, sh}; is_shift = 1'b1; end     // srai
                        5: begin f3 = 3'b110; eop = 4'b0110; end                                         // ori
                        default: begin f3 = 3'b111; eop = 4'b0111; end                                   // andi
                    endcase
                    instr = itype(imm, rs1, f3, rd);
                end
                default: begin
                    legal = 1'b0;
                    k = $urandom_range(0, 7);
                    case (k)
                        0: instr = rtype(7'h00, rs2, rs1, 3'b010, rd);                 // slt
                        1: instr = rtype(7'h00, rs2, rs1, 3'b011, rd);                 // sltu
                        2: instr = rtype(7'h01, rs2, rs1, 3'b000, rd);                 // mul
                        3: instr = itype(imm, rs1, 3'b010, rd);                        // slti
                        4: instr = itype({7'h01, sh}, rs1, 3'b001, rd);                // bad slli
                        5: instr = {imm, rs1, 3'b010, rd, 7'b0000011};                 // lw
                        6: instr = itype({7'h10, sh}, rs1, 3'b101, rd);                // bad srli
                        default: instr = rtype(7'h20, rs2, rs1, 3'b100, rd);           // bad alt xor
                    endcase
                end
            endcase
            byp = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: wr = rs1;
                1: wr = rs2;
                default: wr = 5'($urandom_range(0, 31));
            endcase
            wd = $urandom;
            e1 = src_val(rs1, byp, wr, wd);
            if (is_r) e2 = src_val(rs2, byp, wr, wd);
            else if (is_shift) e2 = {27'd0, sh};
            else e2 = {{20{imm[11]}}, imm};

            instruction = instr; in_valid = 1'b1;
            wb_valid = byp; wb_rd = wr; wb_data = wd; #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rnd%0d_ready: got %b want 1", n, in_ready); end
            step(); in_valid = 1'b0; wb_valid = 1'b0;
            if (byp && (wr != 5'd0)) model_rf[wr] = wd;
            if (legal) begin
                n_cmp++; if ({out_valid, illegal, operation, operand1, operand2, out_rd} !== {1'b1, 1'b0, eop, e1, e2, rd}) begin
                    n_err++; $display("FAIL rnd%0d_issue instr=%h: got %h want %h", n, instr, {out_valid, illegal, operation, operand1, operand2, out_rd}, {1'b1, 1'b0, eop, e1, e2, rd});
                end
                last_rd = rd;
            end else begin
                n_cmp++; if ({out_valid, illegal, out_rd} !== {1'b0, 1'b1, last_rd}) begin
                    n_err++; $display("FAIL rnd%0d_illegal instr=%h: got %h want %h", n, instr, {out_valid, illegal, out_rd}, {1'b0, 1'b1, last_rd});
                end
            end
            do_wb(rd, $urandom);
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_sub();
        test_imm();
        test_hazard();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
